// File: rtl/fifo2linebuf_if.sv
// fifo2linebuf_if: receive-FIFO read port plus line-RAM write port and status pulses.
// err_cnt exists only when FIFO2LB_STATS_EN is defined.
interface fifo2linebuf_if #(parameter int IDX_W = 10);
   logic [28:0] fifo_dout;
   logic fifo_empty;
   logic fifo_rd_en;
   logic lb_we;
   logic [IDX_W+1:0] lb_addr;
   logic [15:0] lb_wdata;
   logic line_done;
   logic [10:0] line_num;
   logic err_short;
   logic err_long;
`ifdef FIFO2LB_STATS_EN
   logic [15:0] err_cnt;
   modport slave (input fifo_dout, fifo_empty,
                  output fifo_rd_en, lb_we, lb_addr, lb_wdata, line_done, line_num, err_short, err_long, err_cnt);
   modport master (output fifo_dout, fifo_empty,
                   input fifo_rd_en, lb_we, lb_addr, lb_wdata, line_done, line_num, err_short, err_long, err_cnt);
`else
   modport slave (input fifo_dout, fifo_empty,
                  output fifo_rd_en, lb_we, lb_addr, lb_wdata, line_done, line_num, err_short, err_long);
   modport master (output fifo_dout, fifo_empty,
                   input fifo_rd_en, lb_we, lb_addr, lb_wdata, line_done, line_num, err_short, err_long);
`endif
endinterface

// File: rtl/fifo2linebuf.sv
// fifo2linebuf: drains 29-bit pixel words from the receive FIFO into a ping-pong line RAM,
// rebuilding pixel index and checking packet length; FIFO2LB_STATS_EN adds a saturating err_cnt.
module fifo2linebuf #(
   parameter int PKT_PIXELS = 640,
   parameter int IDX_W = 10
) (
   input logic clk125,
   input logic sys_rst,
   fifo2linebuf_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DROP} state_e;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_PIXELS - 1);
   localparam logic [IDX_W-1:0] ONE = IDX_W'(1);
   state_e state_q, state_d;
   logic rd_vld_q;
   logic [11:0] hdr, cur_hdr_q, cur_hdr_d, last_hdr_q, last_hdr_d;
   logic [IDX_W-1:0] cur_idx_q, cur_idx_d, wr_idx;
   logic last_vld_q, last_vld_d;
   logic wr, start, done, es, el;
   logic lb_we_q, line_done_q, err_short_q, err_long_q;
   logic [IDX_W+1:0] lb_addr_q;
   logic [15:0] lb_wdata_q;
   logic [10:0] line_num_q;
   logic unused_rsvd;
   assign bus.fifo_rd_en = !bus.fifo_empty && !sys_rst;
   assign hdr = bus.fifo_dout[27:16];
   assign unused_rsvd = bus.fifo_dout[28];
   // hdr = {half, line}; a write at LAST_IDX closes the packet regardless of how it started
   always_comb begin
      state_d = state_q;
      cur_hdr_d = cur_hdr_q;
      cur_idx_d = cur_idx_q;
      last_hdr_d = last_hdr_q;
      last_vld_d = last_vld_q;
      start = 1'b0;
      wr = 1'b0;
      wr_idx = '0;
      es = 1'b0;
      el = 1'b0;
      done = 1'b0;
      if (rd_vld_q) begin
         case (state_q)
            IDLE: begin
               el = last_vld_q && hdr == last_hdr_q;
               start = !el;
               state_d = el ? DROP : state_q;
            end
            RUN: begin
               wr = hdr == cur_hdr_q;
               wr_idx = cur_idx_q;
               cur_idx_d = wr ? cur_idx_q + ONE : cur_idx_q;
               es = !wr;
               start = !wr;
            end
            DROP: start = hdr != last_hdr_q;
            default: state_d = IDLE;
         endcase
         if (start) begin
            wr = 1'b1;
            wr_idx = '0;
            cur_hdr_d = hdr;
            cur_idx_d = ONE;
            state_d = RUN;
         end
         if (wr && wr_idx == LAST_IDX) begin
            last_hdr_d = hdr;
            last_vld_d = 1'b1;
            cur_idx_d = '0;
            state_d = IDLE;
            done = hdr[11];
         end
      end
   end
   always_ff @(posedge clk125 or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= IDLE;
         rd_vld_q <= 1'b0;
         cur_hdr_q <= '0;
         cur_idx_q <= '0;
         last_hdr_q <= '0;
         last_vld_q <= 1'b0;
         lb_we_q <= 1'b0;
         lb_addr_q <= '0;
         lb_wdata_q <= '0;
         line_done_q <= 1'b0;
         line_num_q <= '0;
         err_short_q <= 1'b0;
         err_long_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_vld_q <= bus.fifo_rd_en;
         cur_hdr_q <= cur_hdr_d;
         cur_idx_q <= cur_idx_d;
         last_hdr_q <= last_hdr_d;
         last_vld_q <= last_vld_d;
         lb_we_q <= wr;
         lb_addr_q <= wr ? {hdr[0], hdr[11], wr_idx} : lb_addr_q;
         lb_wdata_q <= wr ? bus.fifo_dout[15:0] : lb_wdata_q;
         line_done_q <= done;
         line_num_q <= done ? hdr[10:0] : line_num_q;
         err_short_q <= es;
         err_long_q <= el;
      end
   end
   assign bus.lb_we = lb_we_q;
   assign bus.lb_addr = lb_addr_q;
   assign bus.lb_wdata = lb_wdata_q;
   assign bus.line_done = line_done_q;
   assign bus.line_num = line_num_q;
   assign bus.err_short = err_short_q;
   assign bus.err_long = err_long_q;
`ifdef FIFO2LB_STATS_EN
   logic [15:0] err_cnt_q;
   always_ff @(posedge clk125 or posedge sys_rst) begin
      if (sys_rst) err_cnt_q <= '0;
      else if ((es || el) && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
   end
   assign bus.err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_fifo2linebuf.sv
// tb_fifo2linebuf: scoreboard bench for fifo2linebuf; expected RAM writes and pulses are queued as
// words are driven and matched against DUT output. Stats scenarios run when FIFO2LB_STATS_EN is defined.
module tb_fifo2linebuf;
   typedef struct packed {
      logic we;
      logic [11:0] addr;
      logic [15:0] d;
      logic done;
      logic [10:0] ln;
      logic es;
      logic el;
   } ev_t;
   logic clk125 = 1'b0;
   logic sys_rst = 1'b0;
   always #4 clk125 = ~clk125;
   fifo2linebuf_if #(.IDX_W(10)) bus ();
   fifo2linebuf #(.PKT_PIXELS(640), .IDX_W(10)) dut (.clk125(clk125), .sys_rst(sys_rst), .bus(bus.slave));
   ev_t exp_q[$];
   int checks = 0;
   int failures = 0;
   logic [28:0] nxt_w = '0;
   logic chk_lat = 1'b0;
   logic [1:0] rd_hist = '0;

   function automatic ev_t ev(input logic we, input logic [11:0] a, input logic [15:0] d,
                              input logic dn, input logic [10:0] ln, input logic es, input logic el);
      return {we, a, d, dn, ln, es, el};
   endfunction

   task automatic cyc(input logic e, input logic [28:0] w);
      @(posedge clk125);
      #1;
      bus.fifo_dout = nxt_w;
      bus.fifo_empty = e;
      nxt_w = w;
   endtask

   task automatic send(input logic h, input logic [10:0] ln, input logic [15:0] px);
      cyc(1'b0, {1'b0, h, ln, px});
   endtask

   task automatic pkt(input logic h, input logic [10:0] ln, input int n, input logic es0, input logic bursty);
      logic [15:0] px;
      logic last;
      for (int i = 0; i < n; i++) begin
         px = 16'($urandom);
         last = h && i == 639;
         if (bursty) while ($urandom_range(0, 2) == 0) cyc(1'b1, '0);
         exp_q.push_back(ev(1'b1, {ln[0], h, 10'(i)}, px, last, last ? ln : 11'd0, es0 && i == 0, 1'b0));
         send(h, ln, px);
      end
   endtask

   task automatic drain(input string name);
      repeat (5) cyc(1'b1, '0);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s pending=%0d required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic monitor();
      ev_t act, e;
      forever begin
         @(negedge clk125);
         if (chk_lat) begin
            checks++;
            if (bus.lb_we !== rd_hist[1]) begin
               failures++;
               $display("FAIL latency lb_we=%b required %b", bus.lb_we, rd_hist[1]);
            end
         end
         rd_hist = {rd_hist[0], bus.fifo_rd_en};
         if (!sys_rst && (bus.lb_we || bus.line_done || bus.err_short || bus.err_long)) begin
            act = ev(bus.lb_we, bus.lb_we ? bus.lb_addr : 12'd0, bus.lb_we ? bus.lb_wdata : 16'd0,
                     bus.line_done, bus.line_done ? bus.line_num : 11'd0, bus.err_short, bus.err_long);
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_event got we=%b addr=%h done=%b es=%b el=%b required none",
                        act.we, act.addr, act.done, act.es, act.el);
            end else begin
               e = exp_q.pop_front();
               if (act !== e) begin
                  failures++;
                  $display("FAIL event got we=%b addr=%h d=%h done=%b ln=%0d es=%b el=%b required we=%b addr=%h d=%h done=%b ln=%0d es=%b el=%b",
                           act.we, act.addr, act.d, act.done, act.ln, act.es, act.el,
                           e.we, e.addr, e.d, e.done, e.ln, e.es, e.el);
               end
            end
         end
      end
   endtask

   task automatic test_reset();
      @(posedge clk125);
      #1;
      sys_rst = 1'b1;
      bus.fifo_empty = 1'b0;
      bus.fifo_dout = '0;
      nxt_w = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk125);
         checks++;
         if (bus.fifo_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_rd_en got %b required 0", bus.fifo_rd_en);
         end
         checks++;
         if ({bus.lb_we, bus.lb_addr, bus.lb_wdata, bus.line_done, bus.line_num, bus.err_short, bus.err_long} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got we=%b addr=%h d=%h done=%b ln=%h es=%b el=%b required all 0",
                     bus.lb_we, bus.lb_addr, bus.lb_wdata, bus.line_done, bus.line_num, bus.err_short, bus.err_long);
         end
`ifdef FIFO2LB_STATS_EN
         checks++;
         if (bus.err_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_err_cnt got %h required 0000", bus.err_cnt);
         end
`endif
      end
      @(posedge clk125);
      #1;
      bus.fifo_empty = 1'b1;
      sys_rst = 1'b0;
   endtask

   task automatic test_full_line();
      pkt(1'b0, 11'd5, 640, 1'b0, 1'b0);
      pkt(1'b1, 11'd5, 640, 1'b0, 1'b0);
      drain("full_line");
   endtask

   task automatic test_short();
      pkt(1'b0, 11'd6, 100, 1'b0, 1'b0);
      pkt(1'b1, 11'd6, 640, 1'b1, 1'b0);
      drain("short_packet");
   endtask

   task automatic test_long();
      pkt(1'b0, 11'd7, 640, 1'b0, 1'b0);
      exp_q.push_back(ev(1'b0, 12'd0, 16'd0, 1'b0, 11'd0, 1'b0, 1'b1));
      for (int i = 0; i < 5; i++) send(1'b0, 11'd7, 16'(16'hA000 + i));
      exp_q.push_back(ev(1'b1, {1'b1, 1'b1, 10'd0}, 16'hBEEF, 1'b0, 11'd0, 1'b0, 1'b0));
      send(1'b1, 11'd7, 16'hBEEF);
      drain("long_packet");
   endtask

   task automatic test_reset_mid();
      pkt(1'b0, 11'd8, 300, 1'b1, 1'b0);
      drain("pre_reset");
      test_reset();
      pkt(1'b0, 11'd8, 640, 1'b0, 1'b0);
      drain("resend_after_reset");
   endtask

   task automatic test_back_to_back();
      chk_lat = 1'b1;
      pkt(1'b0, 11'd9, 640, 1'b0, 1'b1);
      pkt(1'b1, 11'd9, 640, 1'b0, 1'b1);
      drain("bursty_line");
      chk_lat = 1'b0;
   endtask

`ifdef FIFO2LB_STATS_EN
   task automatic test_stats();
      test_reset();
      pkt(1'b0, 11'd12, 640, 1'b0, 1'b0);
      exp_q.push_back(ev(1'b0, 12'd0, 16'd0, 1'b0, 11'd0, 1'b0, 1'b1));
      send(1'b0, 11'd12, 16'h1234);
      pkt(1'b1, 11'd12, 640, 1'b0, 1'b0);
      exp_q.push_back(ev(1'b0, 12'd0, 16'd0, 1'b0, 11'd0, 1'b0, 1'b1));
      send(1'b1, 11'd12, 16'h5678);
      pkt(1'b0, 11'd10, 2, 1'b0, 1'b0);
      pkt(1'b1, 11'd10, 2, 1'b1, 1'b0);
      pkt(1'b0, 11'd11, 2, 1'b1, 1'b0);
      pkt(1'b1, 11'd11, 2, 1'b1, 1'b0);
      drain("stats_errors");
      checks++;
      if (bus.err_cnt !== 16'd5) begin
         failures++;
         $display("FAIL err_cnt got %0d required 5", bus.err_cnt);
      end
      for (int k = 0; k < 65530; k++) pkt(k[0], 11'd13, 1, 1'b1, 1'b0);
      drain("stats_fill");
      checks++;
      if (bus.err_cnt !== 16'hFFFF) begin
         failures++;
         $display("FAIL err_cnt_full got %h required ffff", bus.err_cnt);
      end
      pkt(1'b0, 11'd13, 1, 1'b1, 1'b0);
      drain("stats_sat");
      checks++;
      if (bus.err_cnt !== 16'hFFFF) begin
         failures++;
         $display("FAIL err_cnt_sat got %h required ffff", bus.err_cnt);
      end
   endtask
`endif

   initial begin
      bus.fifo_empty = 1'b1;
      bus.fifo_dout = '0;
      fork
         monitor();
      join_none
      test_reset();
      test_full_line();
      test_short();
      test_long();
      test_reset_mid();
      test_back_to_back();
`ifdef FIFO2LB_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
